// File: rtl/imem_arbiter.sv
// Arbiter sharing a single-port synchronous-read instruction RAM between CPU fetch and a loader.
// Optional burst watchdog: define IMEM_ARB_BURST_TIMEOUT_EN to force-release stalled bursts.
module imem_arbiter #(
    parameter int NUM_INST     = 128,
    parameter int AW           = 7,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [31:0]   fetch_instr,
    output logic          fetch_err,
    input  logic          load_req,
    input  logic          load_we,
    input  logic [31:0]   load_addr,
    input  logic [31:0]   load_wdata,
    input  logic          load_last,
    output logic          load_gnt,
    output logic          load_valid,
    output logic [31:0]   load_rdata,
    output logic          load_err,
    output logic          load_abort,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic RR_FETCH = 1'b0;
    localparam logic RR_LOAD  = 1'b1;

    state_t        state;
    logic          rr_last;
    logic [AW-1:0] addr_q;
    logic          f_vld, f_err, l_vld, l_err, l_rd;
    logic          f_ok, l_ok;

    function automatic logic in_range(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(NUM_INST));
    endfunction

    assign f_ok = in_range(fetch_pc);
    assign l_ok = in_range(load_addr);

    // No grants at all while reset is asserted, so the RAM is never written during reset.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (rst_n) begin
            if (state == LOCK) begin
                load_gnt = load_req;
            end else if (fetch_req && load_req) begin
                fetch_gnt = (rr_last == RR_LOAD);
                load_gnt  = (rr_last == RR_FETCH);
            end else begin
                fetch_gnt = fetch_req;
                load_gnt  = load_req;
            end
        end
    end

    always_comb begin
        mem_addr = addr_q;
        if (fetch_gnt)
            mem_addr = fetch_pc[AW+1:2];
        else if (load_gnt)
            mem_addr = load_addr[AW+1:2];
    end

    assign mem_we    = load_gnt & load_we & l_ok;
    assign mem_wdata = load_wdata;

    // RAM data arrives the cycle after the grant, so the data outputs gate it with the registered flags.
    assign fetch_valid = f_vld;
    assign fetch_err   = f_err;
    assign fetch_instr = (f_vld && !f_err) ? mem_rdata : 32'h0;
    assign load_valid  = l_vld;
    assign load_err    = l_err;
    assign load_rdata  = l_rd ? mem_rdata : 32'h0;

`ifdef IMEM_ARB_BURST_TIMEOUT_EN
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          abort_q;
    assign load_abort = abort_q;
`else
    assign load_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= RR_LOAD;
            addr_q  <= '0;
            f_vld   <= 1'b0;
            f_err   <= 1'b0;
            l_vld   <= 1'b0;
            l_err   <= 1'b0;
            l_rd    <= 1'b0;
`ifdef IMEM_ARB_BURST_TIMEOUT_EN
            idle_cnt <= '0;
            abort_q  <= 1'b0;
`endif
        end else begin
            f_vld <= fetch_gnt;
            f_err <= fetch_gnt & ~f_ok;
            l_vld <= load_gnt;
            l_err <= load_gnt & ~l_ok;
            l_rd  <= load_gnt & l_ok & ~load_we;
            if (fetch_gnt || load_gnt)
                addr_q <= mem_addr;

            case (state)
                IDLE: begin
                    if (fetch_gnt) begin
                        rr_last <= RR_FETCH;
                    end else if (load_gnt) begin
                        rr_last <= RR_LOAD;
                        if (!load_last)
                            state <= LOCK;
                    end
                end
                LOCK: begin
                    if (load_gnt && load_last) begin
                        state   <= IDLE;
                        rr_last <= RR_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef IMEM_ARB_BURST_TIMEOUT_EN
            // Count idle cycles inside a burst; reaching LOAD_TIMEOUT releases the lock.
            abort_q <= 1'b0;
            if (state == LOCK && !load_req) begin
                if (idle_cnt == TW'(LOAD_TIMEOUT - 1)) begin
                    state    <= IDLE;
                    rr_last  <= RR_LOAD;
                    abort_q  <= 1'b1;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios then random traffic against a word-level reference model.
module tb_imem_arbiter;

    localparam int NI = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic          fetch_gnt, fetch_valid, fetch_err;
    logic [31:0]   fetch_instr;
    logic          load_req = 1'b0, load_we = 1'b0, load_last = 1'b0;
    logic [31:0]   load_addr = '0, load_wdata = '0;
    logic          load_gnt, load_valid, load_err, load_abort;
    logic [31:0]   load_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    imem_arbiter #(.NUM_INST(NI), .AW(AW), .LOAD_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .load_req(load_req), .load_we(load_we), .load_addr(load_addr),
        .load_wdata(load_wdata), .load_last(load_last), .load_gnt(load_gnt),
        .load_valid(load_valid), .load_rdata(load_rdata), .load_err(load_err),
        .load_abort(load_abort),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM, loaded from seed while init_ram is high.
    logic [31:0] ram  [NI];
    logic [31:0] seed [NI];
    logic        init_ram = 1'b1;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < NI; i++) ram[i] <= seed[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    // Reference model state: memory contents, lock flag, who won the last arbitration.
    logic [31:0] mdl [NI];
    bit          locked    = 1'b0;
    bit          last_load = 1'b1;
    int          idle      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < NI);
    endfunction

    task automatic model_reset();
        locked    = 1'b0;
        last_load = 1'b1;
        idle      = 0;
    endtask

    // One clock: drive, check grants mid-cycle, predict, then check the responses after the edge.
    task automatic step(input bit fr, input logic [31:0] fpc, input bit lr, input bit lwe,
                        input logic [31:0] la, input logic [31:0] lwd, input bit ll,
                        output bit gf, output bit gl);
        bit          ef_v, ef_e, el_v, el_e, ea;
        logic [31:0] ef_d, el_d;
        fetch_req = fr; fetch_pc = fpc;
        load_req = lr; load_we = lwe; load_addr = la; load_wdata = lwd; load_last = ll;
        #2;
        if (locked) begin
            gf = 1'b0; gl = lr;
        end else if (fr && lr) begin
            gf = last_load; gl = !last_load;
        end else begin
            gf = fr; gl = lr;
        end
        chk("fetch_gnt", 32'(fetch_gnt), 32'(gf));
        chk("load_gnt", 32'(load_gnt), 32'(gl));
        chk("mem_we", 32'(mem_we), 32'(gl && lwe && legal(la)));
        if (gf) chk("mem_addr_f", 32'(mem_addr), (fpc >> 2) % NI);
        if (gl) chk("mem_addr_l", 32'(mem_addr), (la >> 2) % NI);

        ef_v = gf; ef_e = gf && !legal(fpc);
        ef_d = (gf && legal(fpc)) ? mdl[fpc >> 2] : 32'h0;
        el_v = gl; el_e = gl && !legal(la);
        el_d = (gl && legal(la) && !lwe) ? mdl[la >> 2] : 32'h0;
        if (gl && lwe && legal(la)) mdl[la >> 2] = lwd;
        ea = 1'b0;

        if (!locked) begin
            if (gf) last_load = 1'b0;
            else if (gl) begin last_load = 1'b1; locked = !ll; idle = 0; end
        end else if (gl) begin
            idle = 0;
            if (ll) begin locked = 1'b0; last_load = 1'b1; end
        end else begin
`ifdef IMEM_ARB_BURST_TIMEOUT_EN
            idle++;
            if (idle == 16) begin locked = 1'b0; last_load = 1'b1; ea = 1'b1; idle = 0; end
`endif
        end

        @(posedge clk); #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(ef_v));
        chk("fetch_err", 32'(fetch_err), 32'(ef_e));
        chk("fetch_instr", fetch_instr, ef_d);
        chk("load_valid", 32'(load_valid), 32'(el_v));
        chk("load_err", 32'(load_err), 32'(el_e));
        chk("load_rdata", load_rdata, el_d);
        chk("load_abort", 32'(load_abort), 32'(ea));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return 32'($urandom_range(0, NI - 1)) << 2;
        if (r == 8) return (32'($urandom_range(0, NI - 1)) << 2) | 32'($urandom_range(1, 3));
        return 32'(NI * 4) + (32'($urandom_range(0, 255)) << 2);
    endfunction

    initial begin
        bit gf, gl;
        bit pf, pl, plwe, plast;
        logic [31:0] ppc, pla, plwd;
        int beats_left;

        for (int i = 0; i < NI; i++) seed[i] = $urandom;
        seed[0] = 32'h07B00293; seed[1] = 32'h1C800313; seed[2] = 32'h006283B3;
        for (int i = 0; i < NI; i++) mdl[i] = seed[i];

        // Reset: requests asserted, nothing may be granted or written.
        fetch_req = 1'b1; load_req = 1'b1; load_we = 1'b1; load_addr = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_fetch_gnt", 32'(fetch_gnt), 0);
        chk("rst_load_gnt", 32'(load_gnt), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_load_valid", 32'(load_valid), 0);
        chk("rst_fetch_instr", fetch_instr, 0);
        chk("rst_load_rdata", load_rdata, 0);
        chk("rst_errs", {30'b0, fetch_err, load_err}, 0);
        chk("rst_abort", 32'(load_abort), 0);
        init_ram = 1'b0; rst_n = 1'b1;
        model_reset();

        // Tie from reset: fetch first, then alternating.
        step(1, 32'hC, 1, 0, 32'h20, 0, 1, gf, gl);
        chk("tie1_fetch_first", 32'(gf), 1);
        step(1, 32'h10, 1, 0, 32'h20, 0, 1, gf, gl);
        chk("tie2_load", 32'(gl), 1);
        step(1, 32'h10, 1, 0, 32'h24, 0, 1, gf, gl);
        step(1, 32'h14, 1, 0, 32'h24, 0, 1, gf, gl);

        // Back-to-back fetches of the preloaded words.
        step(1, 32'h0, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'h4, 0, 0, 0, 0, 0, gf, gl);
        chk("fetch0_word", fetch_instr, 32'h1C800313);
        step(1, 32'h8, 0, 0, 0, 0, 0, gf, gl);
        chk("fetch1_word", fetch_instr, 32'h006283B3);

        // Locked write burst with fetch held; gap cycle inside the burst.
        step(0, 0, 1, 1, 32'h10, 32'hA, 0, gf, gl);
        step(1, 32'h14, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'h14, 1, 1, 32'h14, 32'hB, 0, gf, gl);
        step(1, 32'h14, 1, 1, 32'h18, 32'hC, 1, gf, gl);
        chk("burst_fetch_blocked", 32'(gf), 0);
        step(1, 32'h14, 0, 0, 0, 0, 0, gf, gl);
        chk("burst_readback", fetch_instr, 32'hB);

        // Illegal addresses; an out-of-range write aliasing word 0 must not land.
        step(1, 32'h202, 0, 0, 0, 0, 0, gf, gl);
        step(1, 32'h200, 0, 0, 0, 0, 0, gf, gl);
        step(0, 0, 1, 1, 32'h400, 32'hDEAD, 1, gf, gl);
        step(1, 32'h0, 0, 0, 0, 0, 0, gf, gl);
        chk("alias_intact", fetch_instr, 32'h07B00293);

        // Reset with beat 2 of a burst granted but not yet completed.
        step(0, 0, 1, 1, 32'h40, 32'h1234, 0, gf, gl);
        fetch_req = 1'b1; fetch_pc = 32'h40;
        load_req = 1'b1; load_we = 1'b1; load_addr = 32'h44; load_wdata = 32'h5678; load_last = 1'b0;
        #2;
        chk("mid_load_gnt", 32'(load_gnt), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", {30'b0, fetch_gnt, load_gnt}, 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        chk("mid_rst_valid", {30'b0, fetch_valid, load_valid}, 0);
        @(posedge clk); #1;
        chk("mid_rst_no_valid", {30'b0, fetch_valid, load_valid}, 0);
        rst_n = 1'b1;
        model_reset();
        step(1, 32'h40, 0, 0, 0, 0, 0, gf, gl);
        chk("post_rst_fetch_gnt", 32'(gf), 1);
        step(1, 32'h44, 0, 0, 0, 0, 0, gf, gl);

        // Stalled burst: released by the watchdog when enabled, otherwise fetch stays blocked.
        step(0, 0, 1, 0, 32'h8, 0, 0, gf, gl);
        for (int i = 0; i < 17; i++) step(1, 32'h4, 0, 0, 0, 0, 0, gf, gl);
`ifdef IMEM_ARB_BURST_TIMEOUT_EN
        chk("timeout_fetch_gnt", 32'(gf), 1);
`else
        chk("locked_fetch_gnt", 32'(gf), 0);
`endif
        step(1, 32'h4, 1, 0, 32'hC, 0, 1, gf, gl);
        step(1, 32'h4, 0, 0, 0, 0, 0, gf, gl);

        // Random traffic: requests held stable until granted, bursts of 1-3 beats.
        pf = 0; pl = 0; beats_left = 0; plwe = 0; plast = 0;
        ppc = '0; pla = '0; plwd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pf && $urandom_range(0, 2) != 0) begin pf = 1; ppc = rand_addr(); end
            if (!pl) begin
                if (beats_left == 0 && $urandom_range(0, 3) == 0) beats_left = $urandom_range(1, 3);
                if (beats_left > 0 && $urandom_range(0, 2) != 0) begin
                    pl = 1; pla = rand_addr(); plwd = $urandom;
                    plwe = 1'($urandom_range(0, 1)); plast = (beats_left == 1);
                end
            end
            step(pf, ppc, pl, plwe, pla, plwd, plast, gf, gl);
            if (gf) pf = 0;
            if (gl) begin pl = 0; beats_left--; end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
